sync_debounce_edge: RTL and testbench

- Downstream consumer of the setup/hold-checked capture flop's q output.
- Takes that possibly-late or glitchy signal into the clk domain through a synchronizer chain.
- Debounces it and emits a clean level plus one-cycle rise/fall pulses.
- Keeps saturating counters of accepted transitions and rejected glitches for the gate-level timing studies.

---
 rtl/sync_debounce_edge.sv | 141 ++++++++++++++
 tb/tb_sync_debounce_edge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// Synchronizes a raw, possibly late or glitchy input into clk, debounces it, and
// emits a clean level, one-cycle rise/fall pulses and saturating event counters.
module sync_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_async,
  input  logic             en,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] glitch_count
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_debounce_edge: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("sync_debounce_edge: DEBOUNCE_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sync_debounce_edge: CNT_W must be >= 1");
  end

  localparam int               CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic {STABLE, CANDIDATE} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       edge_q, edge_d;
  logic [CNT_W-1:0]       glitch_q, glitch_d;
  logic                   accept, glitch;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    edge_d   = edge_q;
    glitch_d = glitch_q;
    accept   = 1'b0;
    glitch   = 1'b0;

    if (!en) begin
      // Aborted candidates are dropped silently, not counted as glitches.
      state_d = STABLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE: begin
          if (synced != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = CANDIDATE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CANDIDATE: begin
          if (synced == level_q) begin
            glitch  = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (accept) begin
      level_d = synced;
      rise_d  = synced;
      fall_d  = ~synced;
      state_d = STABLE;
      cnt_d   = '0;
    end

    // clr has priority over a same-cycle increment.
    if (clr) begin
      edge_d   = '0;
      glitch_d = '0;
    end else begin
      if (accept && edge_q != CNT_SAT)   edge_d   = edge_q + CNT_W'(1);
      if (glitch && glitch_q != CNT_SAT) glitch_d = glitch_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= STABLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_async};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
      glitch_q <= glitch_d;
    end
  end

  assign level        = level_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign edge_count   = edge_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios plus random input runs compared
// against a run-length model of the debounce rules.
module tb_sync_debounce_edge;

  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, d_async, en, clr;
  logic          level, rise, fall;
  logic [CW-1:0] edge_count, glitch_count;

  int total = 0;
  int bad   = 0;

  bit m_dq[$];
  bit m_level, m_rise, m_fall;
  int m_run, m_edge, m_glitch;

  always #5 clk = ~clk;

  sync_debounce_edge #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_async     (d_async),
    .en          (en),
    .clr         (clr),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .edge_count  (edge_count),
    .glitch_count(glitch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dq.delete();
    for (int i = 0; i < SS; i++) m_dq.push_back(1'b0);
    m_level = 0; m_rise = 0; m_fall = 0;
    m_run = 0; m_edge = 0; m_glitch = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"},  level,        m_level);
    chk({tag, ".rise"},   rise,         m_rise);
    chk({tag, ".fall"},   fall,         m_fall);
    chk({tag, ".edges"},  edge_count,   m_edge);
    chk({tag, ".glitch"}, glitch_count, m_glitch);
    chk({tag, ".excl"},   rise & fall,  1'b0);
  endtask

  // Inputs are set before the call and held across the edge; the model consumes
  // the value seen SS edges ago as the synchronized sample.
  task automatic tick(input string tag);
    bit a_d, a_en, a_clr, sy, acc, gl;
    a_d = d_async; a_en = en; a_clr = clr;
    @(posedge clk);
    sy = m_dq.pop_front();
    m_dq.push_back(a_d);
    m_rise = 0; m_fall = 0; acc = 0; gl = 0;
    if (!a_en) begin
      m_run = 0;
    end else if (sy != m_level) begin
      m_run++;
      if (m_run == DB) begin
        acc = 1; m_run = 0; m_level = sy; m_rise = sy; m_fall = !sy;
      end
    end else begin
      gl = (m_run > 0);
      m_run = 0;
    end
    if (a_clr) begin
      m_edge = 0; m_glitch = 0;
    end else begin
      if (acc && m_edge < CMAX)  m_edge++;
      if (gl && m_glitch < CMAX) m_glitch++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; d_async = 1'b0; en = 1'b1; clr = 1'b0;
    model_reset();

    // Reset held with a toggling input.
    for (int i = 0; i < 3; i++) begin
      d_async = (i % 2 == 0);
      @(posedge clk); #1;
      check_all("in_reset");
    end
    rst_n = 1'b1; d_async = 1'b0;
    repeat (10) tick("post_reset");

    // Clean rise then fall: level changes on the 6th edge counted from the capture edge.
    #7 d_async = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick("rise_seq");
      chk("rise_lat.level", level, (i >= 6));
      chk("rise_lat.pulse", rise, (i == 6));
    end
    chk("rise.edges", edge_count, 1);
    d_async = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick("fall_seq");
      chk("fall_lat.level", level, (i < 6));
      chk("fall_lat.pulse", fall, (i == 6));
    end
    chk("fall.edges", edge_count, 2);

    // Two-cycle pulse is rejected.
    clr = 1'b1; tick("clr"); clr = 1'b0;
    d_async = 1'b1; repeat (2) tick("glitch_hi");
    d_async = 1'b0; repeat (10) tick("glitch_lo");
    chk("glitch.level",  level, 0);
    chk("glitch.count",  glitch_count, 1);
    chk("glitch.edges",  edge_count, 0);

    // Saturation at 3, then clr coinciding with a 6th acceptance.
    for (int t = 0; t < 5; t++) begin
      d_async = ~d_async;
      repeat (8) tick("sat");
    end
    chk("sat.edges", edge_count, CMAX);
    chk("sat.level", level, 1);
    d_async = 1'b0;
    repeat (5) tick("sat6");
    clr = 1'b1; tick("clr_acc"); clr = 1'b0;
    chk("clr_acc.edges", edge_count, 0);
    chk("clr_acc.fall",  fall, 1);
    chk("clr_acc.level", level, 0);

    // Async reset during the third candidate cycle.
    d_async = 1'b1; repeat (8) tick("pre_r");
    d_async = 1'b0; repeat (8) tick("pre_f");
    chk("pre.edges", edge_count, 2);
    d_async = 1'b1; repeat (5) tick("cand");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.level",  level, 0);
    chk("mid_rst.rise",   rise, 0);
    chk("mid_rst.fall",   fall, 0);
    chk("mid_rst.edges",  edge_count, 0);
    chk("mid_rst.glitch", glitch_count, 0);
    model_reset();
    d_async = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("after_rst");
      chk("after_rst.rise", rise, 0);
    end
    chk("after_rst.edges", edge_count, 0);

    // Enable gating.
    en = 1'b0; d_async = 1'b1;
    repeat (10) tick("en_off");
    chk("en_off.level",  level, 0);
    chk("en_off.glitch", glitch_count, 0);
    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick("en_on");
      chk("en_on.level", level, (i >= DB));
      chk("en_on.rise",  rise, (i == DB));
    end
    chk("en_on.edges", edge_count, 1);

    // Random runs with occasional enable drops and clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) d_async = ~d_async;
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
